sram_1rw_arbiter: RTL and testbench

Two-requester round-robin controller for the single-port 32x1024 sky130 OpenRAM macro, which has byte write masks. It sits between two on-chip masters and the macro, and serialises their read and write requests onto the single RW port. It optionally zero-fills the array after reset. It holds read data in a one-entry response buffer per requester, so a stalled consumer never loses data.

---
 rtl/sram_1rw_arbiter_if.sv | 18 +
 rtl/sram_1rw_arbiter.sv | 93 +++++++++
 tb/tb_sram_1rw_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sram_1rw_arbiter_if.sv
// sram_1rw_arbiter_if: request/response bundle for the two requesters of sram_1rw_arbiter.
interface sram_1rw_arbiter_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic [1:0]         req_valid, req_ready, req_we, rsp_valid, rsp_ready;
   logic [1:0][3:0]    req_wmask;
   logic [1:0][AW-1:0] req_addr;
   logic [1:0][DW-1:0] req_wdata, rsp_rdata;
   modport master (
      output req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );
   modport slave (
      input  req_valid, req_we, req_wmask, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: round-robin two-requester controller for a 1RW OpenRAM macro,
// with optional post-reset zero fill and a one-entry read response slot per requester.
module sram_1rw_arbiter #(
   parameter int AW        = 10,
   parameter int DW        = 32,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic              clk0,
   input  logic              rst0_n,
   sram_1rw_arbiter_if.slave bus,
   output logic              init_done,
   output logic              csb0,
   output logic              web0,
   output logic [3:0]        wmask0,
   output logic              spare_wen0,
   output logic [AW:0]       addr0,
   output logic [DW:0]       din0,
   input  logic [DW:0]       dout0
);
   typedef enum logic {INIT, RUN} state_e;
   typedef enum logic [1:0] {EMPTY, PENDING, FULL} slot_e;
   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          init_done_q, last_q, last_d, run, win, gnt;
   logic [1:0]    elig;
   logic          unused_dout_msb;
   assign unused_dout_msb = dout0[DW];
   assign spare_wen0 = 1'b0;
   assign init_done = init_done_q;
   always_comb begin
      run = init_done_q && rst0_n;
      win = &elig ? ~last_q : elig[1];
      gnt = run && |elig;
      last_d = gnt ? win : last_q;
      cnt_d = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
      state_d = state_q == INIT && &cnt_q ? RUN : state_q;
      csb0 = 1'b1;
      web0 = 1'b1;
      wmask0 = 4'h0;
      addr0 = '0;
      din0 = '0;
      if (rst0_n && state_q == INIT) begin
         csb0 = 1'b0;
         web0 = 1'b0;
         wmask0 = 4'hF;
         addr0 = {1'b0, cnt_q};
      end else if (gnt) begin
         csb0 = 1'b0;
         web0 = !bus.req_we[win];
         wmask0 = bus.req_we[win] ? bus.req_wmask[win] : 4'h0;
         addr0 = {1'b0, bus.req_addr[win]};
         din0 = bus.req_we[win] ? {1'b0, bus.req_wdata[win]} : '0;
      end
   end
   always_ff @(posedge clk0) begin
      if (!rst0_n) begin
         state_q <= INIT_ZERO ? INIT : RUN;
         cnt_q <= '0;
         init_done_q <= 1'b0;
         last_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         init_done_q <= state_d == RUN;
         last_q <= last_d;
      end
   end
   for (genvar g = 0; g < 2; g++) begin : g_slot
      slot_e         slot_q, slot_d;
      logic [DW-1:0] rdata_q;
      logic          iss;
      // a full slot may be refilled in the same cycle its consumer drains it
      assign elig[g] = bus.req_valid[g] && (bus.req_we[g] || slot_q == EMPTY ||
                       (slot_q == FULL && bus.rsp_ready[g]));
      assign bus.req_ready[g] = gnt && win == 1'(g);
      assign iss = bus.req_ready[g] && !bus.req_we[g];
      assign bus.rsp_valid[g] = slot_q == FULL;
      assign bus.rsp_rdata[g] = rdata_q;
      always_comb begin
         slot_d = slot_q == PENDING ? FULL :
                  (slot_q == EMPTY || bus.rsp_ready[g]) ? (iss ? PENDING : EMPTY) : FULL;
      end
      always_ff @(posedge clk0) begin
         if (!rst0_n) begin
            slot_q <= EMPTY;
            rdata_q <= '0;
         end else begin
            slot_q <= slot_d;
            if (slot_q == PENDING) rdata_q <= dout0[DW-1:0];
         end
      end
   end
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed bench with a behavioural 1RW byte-masked macro model.
module tb_sram_1rw_arbiter;
   logic        clk0 = 1'b0, rst0_n = 1'b0;
   logic        init_done, csb0, web0, spare_wen0;
   logic [3:0]  wmask0;
   logic [10:0] addr0;
   logic [32:0] din0, dout0;
   logic [31:0] mem [1024];
   logic [1:0]  exp_bp [10] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
   int          n_run = 0, n_fail = 0, errs, a0, a1, got0, got1;

   sram_1rw_arbiter_if #(.AW(10), .DW(32)) bus ();
   sram_1rw_arbiter #(.AW(10), .DW(32), .INIT_ZERO(1'b1)) dut (
      .clk0(clk0), .rst0_n(rst0_n), .bus(bus), .init_done(init_done),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .spare_wen0(spare_wen0),
      .addr0(addr0), .din0(din0), .dout0(dout0)
   );

   always #5 clk0 = ~clk0;

   always @(posedge clk0) begin
      if (!csb0) begin
         if (!web0) begin
            for (int b = 0; b < 4; b++) if (wmask0[b]) mem[addr0[9:0]][b*8 +: 8] <= din0[b*8 +: 8];
         end else dout0 <= {1'b0, mem[addr0[9:0]]};
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.req_valid = '0;
      bus.req_we = '0;
   endtask

   task automatic drv(input int r, input logic we, input logic [3:0] m, input logic [9:0] a, input logic [31:0] d);
      bus.req_valid[r] = 1'b1;
      bus.req_we[r] = we;
      bus.req_wmask[r] = m;
      bus.req_addr[r] = a;
      bus.req_wdata[r] = d;
   endtask

   initial begin
      bus.req_wmask = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = '0;
      idle();
      drv(0, 1'b0, 4'h0, 10'h001, 32'h0);
      drv(1, 1'b0, 4'h0, 10'h002, 32'h0);
      repeat (3) @(negedge clk0);
      #1 chk("rst_idle", {csb0, web0, wmask0, addr0, din0}, {2'b11, 4'h0, 11'h0, 33'h0});
      chk("rst_state", {init_done, bus.rsp_valid, bus.req_ready, spare_wen0}, 64'h0);
      rst0_n = 1'b1;
      errs = 0;
      for (int k = 0; k < 1024; k++) begin
         #1 if ({csb0, web0, wmask0, addr0, din0, init_done, bus.req_ready, spare_wen0} !==
                {2'b00, 4'hF, 11'(k), 33'h0, 1'b0, 2'b00, 1'b0}) errs++;
         @(negedge clk0);
      end
      idle();
      chk("init_seq", errs, 0);
      #1 chk("init_done", init_done, 1);
      chk("init_fill", {mem[0], mem[1023]}, 64'h0);

      bus.rsp_ready = 2'b11;
      @(negedge clk0); drv(0, 1'b1, 4'hF, 10'h3FF, 32'hDEADBEEF);
      #1 chk("wr_ready", bus.req_ready, 2'b01);
      chk("wr_macro", {csb0, web0, wmask0, addr0, din0}, {2'b00, 4'hF, 11'h3FF, 33'h0DEADBEEF});
      @(negedge clk0); drv(0, 1'b0, 4'h0, 10'h3FF, 32'h0);
      #1 chk("rd_macro", {csb0, web0, wmask0, addr0, bus.req_ready}, {2'b01, 4'h0, 11'h3FF, 2'b01});
      @(negedge clk0); idle();
      #1 chk("rd_pending", bus.rsp_valid, 2'b00);
      @(negedge clk0); drv(0, 1'b1, 4'b0010, 10'h3FF, 32'h00005500);
      #1 chk("rd_valid", bus.rsp_valid, 2'b01);
      chk("rd_data", bus.rsp_rdata[0], 32'hDEADBEEF);
      chk("wr2_ready", bus.req_ready, 2'b01);
      @(negedge clk0); drv(0, 1'b0, 4'h0, 10'h3FF, 32'h0);
      #1 chk("rd2_ready", bus.req_ready, 2'b01);
      @(negedge clk0); idle();
      @(negedge clk0);
      #1 chk("rd2_valid", bus.rsp_valid, 2'b01);
      chk("rd2_data", bus.rsp_rdata[0], 32'hDEAD55EF);

      for (int k = 0; k < 8; k++) begin
         @(negedge clk0); idle();
         drv(k / 4, 1'b1, 4'hF, 10'(16 + k), 32'hC0DE0000 + k);
      end
      @(negedge clk0); idle();

      a0 = 0; a1 = 0; got0 = 0; got1 = 0; errs = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk0); idle();
         if (c < 8) begin
            drv(0, 1'b0, 4'h0, 10'(16 + a0), 32'h0);
            drv(1, 1'b0, 4'h0, 10'(20 + a1), 32'h0);
         end
         #1 if (c < 8) chk($sformatf("rr_grant%0d", c), bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (bus.rsp_valid[0]) begin
            if (bus.rsp_rdata[0] !== 32'hC0DE0000 + got0) errs++;
            got0++;
         end
         if (bus.rsp_valid[1]) begin
            if (bus.rsp_rdata[1] !== 32'hC0DE0004 + got1) errs++;
            got1++;
         end
         if (bus.req_ready[0]) a0++;
         if (bus.req_ready[1]) a1++;
      end
      chk("rr_data", errs, 0);
      chk("rr_cnt0", got0, 4);
      chk("rr_cnt1", got1, 4);

      bus.rsp_ready = 2'b01; got0 = 0; errs = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk0); idle();
         if (c < 8) drv(0, 1'b0, 4'h0, 10'h010, 32'h0);
         drv(1, c == 8, 4'hF, c == 8 ? 10'h018 : 10'h015, 32'h12345678);
         #1 chk($sformatf("bp_grant%0d", c), bus.req_ready, exp_bp[c]);
         if (bus.rsp_valid[0]) begin
            if (bus.rsp_rdata[0] !== 32'hC0DE0000) errs++;
            got0++;
         end
         if (c >= 3 && {bus.rsp_valid[1], bus.rsp_rdata[1]} !== {1'b1, 32'hC0DE0005}) errs++;
      end
      chk("bp_data", errs, 0);
      chk("bp_cnt0", got0, 4);
      chk("bp_wr", mem[10'h018], 32'h12345678);
      @(negedge clk0); idle(); bus.rsp_ready = 2'b11;
      #1 chk("bp_release", {bus.rsp_valid[1], bus.rsp_rdata[1]}, {1'b1, 32'hC0DE0005});
      @(negedge clk0);
      #1 chk("bp_drained", bus.rsp_valid, 2'b00);

      @(negedge clk0); drv(0, 1'b0, 4'h0, 10'h3FF, 32'h0);
      #1 chk("mr_ready", bus.req_ready, 2'b01);
      @(negedge clk0); idle(); rst0_n = 1'b0;
      #1 chk("mr_idle", {csb0, web0, wmask0, addr0, din0}, {2'b11, 4'h0, 11'h0, 33'h0});
      errs = 0;
      repeat (2) begin
         @(negedge clk0);
         #1 if (bus.rsp_valid !== 2'b00 || csb0 !== 1'b1) errs++;
      end
      rst0_n = 1'b1;
      #1 chk("mr_restart0", {csb0, web0, wmask0, addr0, din0, init_done}, {2'b00, 4'hF, 11'h0, 33'h0, 1'b0});
      @(negedge clk0);
      #1 chk("mr_restart1", {csb0, web0, addr0, init_done}, {2'b00, 11'h1, 1'b0});
      if (bus.rsp_valid !== 2'b00) errs++;
      chk("mr_no_rsp", errs, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
